// File: rtl/pll_hdmi_cfg.sv
// HDMI PLL reconfiguration controller on the refclk management bus.
// Shadow registers take bus writes. A START write copies them to the active
// cfg_* outputs, holds the PLL in reset, then waits for a qualified lock.
// Optional macro PLL_HDMI_CFG_READBACK_EN makes the shadow registers readable.
module pll_hdmi_cfg #(
    parameter int RST_CYCLES   = 16,
    parameter int LOCK_TIMEOUT = 1000000,
    parameter int LOCK_STABLE  = 4
) (
    input  logic        refclk,
    input  logic        rst,
    input  logic [5:0]  mgmt_address,
    input  logic        mgmt_write,
    input  logic [31:0] mgmt_writedata,
    input  logic        mgmt_read,
    output logic [31:0] mgmt_readdata,
    output logic        mgmt_waitrequest,
    input  logic        pll_locked,
    output logic        pll_rst,
    output logic [15:0] cfg_m,
    output logic [15:0] cfg_n,
    output logic [16:0] cfg_c0,
    output logic [31:0] cfg_k,
    output logic        cfg_valid,
    output logic        busy,
    output logic        lock_err
);

    localparam int RC_W = $clog2(RST_CYCLES + 1);
    localparam int TO_W = $clog2(LOCK_TIMEOUT + 1);
    localparam int ST_W = $clog2(LOCK_STABLE + 1);

    localparam logic [5:0] A_STATUS = 6'h00;
    localparam logic [5:0] A_START  = 6'h02;
    localparam logic [5:0] A_N      = 6'h03;
    localparam logic [5:0] A_M      = 6'h04;
    localparam logic [5:0] A_C0     = 6'h05;
    localparam logic [5:0] A_K      = 6'h07;

    typedef struct packed {
        logic [15:0] n;
        logic [15:0] m;
        logic [16:0] c0;
        logic [31:0] k;
    } cfg_t;

    // Reset values select 148.5 MHz.
    localparam cfg_t CFG_RST = '{n: 16'h0000, m: 16'h0404, c0: 17'h10201, k: 32'hE8F5C239};

    typedef enum logic [1:0] {S_IDLE, S_APPLY, S_RST_HOLD, S_WAIT_LOCK} state_t;

    state_t            state, state_nxt;
    cfg_t              shadow, active;
    logic              sync_ff, locked_q;
    logic [RC_W-1:0]   rst_cnt;
    logic [TO_W-1:0]   to_cnt;
    logic [ST_W-1:0]   stab_cnt;
    logic              wr_acc, start_acc;
    logic              rst_done, lock_ok, lock_tmo;
    logic              apply, pll_rst_nxt;
    logic [31:0]       rd_mux;

    // Writes stall only while a sequence runs; reads are never stalled.
    assign mgmt_waitrequest = busy & mgmt_write;
    assign wr_acc           = mgmt_write & ~mgmt_waitrequest;
    assign start_acc        = wr_acc && (mgmt_address == A_START);

    assign cfg_n  = active.n;
    assign cfg_m  = active.m;
    assign cfg_c0 = active.c0;
    assign cfg_k  = active.k;

    // Two-flop lock synchroniser. It is flushed while the PLL is held in
    // reset so a stale lock from the previous setting can never qualify.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            sync_ff  <= 1'b0;
            locked_q <= 1'b0;
        end else if (pll_rst) begin
            sync_ff  <= 1'b0;
            locked_q <= 1'b0;
        end else begin
            sync_ff  <= pll_locked;
            locked_q <= sync_ff;
        end
    end

    // Saturating sequence counters. Each is cleared outside its own state.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            rst_cnt  <= '0;
            to_cnt   <= '0;
            stab_cnt <= '0;
        end else begin
            if (state != S_RST_HOLD)
                rst_cnt <= '0;
            else if (rst_cnt != RC_W'(RST_CYCLES))
                rst_cnt <= rst_cnt + 1'b1;

            if (state != S_WAIT_LOCK)
                to_cnt <= '0;
            else if (to_cnt != TO_W'(LOCK_TIMEOUT))
                to_cnt <= to_cnt + 1'b1;

            if (state != S_WAIT_LOCK || !locked_q)
                stab_cnt <= '0;
            else if (stab_cnt != ST_W'(LOCK_STABLE))
                stab_cnt <= stab_cnt + 1'b1;
        end
    end

    assign rst_done = (rst_cnt == RC_W'(RST_CYCLES - 1));
    assign lock_ok  = locked_q && (stab_cnt == ST_W'(LOCK_STABLE - 1));
    assign lock_tmo = (to_cnt == TO_W'(LOCK_TIMEOUT - 1));

    // State register.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic. A qualified lock wins over a timeout in the same cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:      if (start_acc) state_nxt = S_APPLY;
            S_APPLY:     state_nxt = S_RST_HOLD;
            S_RST_HOLD:  if (rst_done) state_nxt = S_WAIT_LOCK;
            S_WAIT_LOCK: if (lock_ok || lock_tmo) state_nxt = S_IDLE;
            default:     state_nxt = S_IDLE;
        endcase
    end

    // Output decode. pll_rst is registered from the next state to stay glitch-free.
    always_comb begin
        busy        = (state != S_IDLE);
        apply       = (state == S_APPLY);
        pll_rst_nxt = (state_nxt == S_RST_HOLD);
    end

    // Registered outputs. The active set and cfg_valid change on the same edge.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            pll_rst   <= 1'b0;
            cfg_valid <= 1'b0;
            lock_err  <= 1'b0;
            active    <= CFG_RST;
        end else begin
            pll_rst   <= pll_rst_nxt;
            cfg_valid <= apply;
            if (apply) begin
                active   <= shadow;
                lock_err <= 1'b0;
            end else if (state == S_WAIT_LOCK && lock_tmo && !lock_ok) begin
                lock_err <= 1'b1;
            end
        end
    end

    // Shadow registers take accepted writes only; unmapped addresses drop.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            shadow <= CFG_RST;
        end else if (wr_acc) begin
            case (mgmt_address)
                A_N:     shadow.n  <= mgmt_writedata[15:0];
                A_M:     shadow.m  <= mgmt_writedata[15:0];
                A_C0:    shadow.c0 <= mgmt_writedata[16:0];
                A_K:     shadow.k  <= mgmt_writedata;
                default: ;
            endcase
        end
    end

    // Read mux. Unmapped addresses return zero.
    always_comb begin
        rd_mux = '0;
        case (mgmt_address)
            A_STATUS: rd_mux = {29'd0, lock_err, locked_q, busy};
`ifdef PLL_HDMI_CFG_READBACK_EN
            A_N:      rd_mux = {16'd0, shadow.n};
            A_M:      rd_mux = {16'd0, shadow.m};
            A_C0:     rd_mux = {15'd0, shadow.c0};
            A_K:      rd_mux = shadow.k;
`endif
            default:  rd_mux = '0;
        endcase
    end

    // Read data is registered and valid the cycle after mgmt_read.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst)            mgmt_readdata <= '0;
        else if (mgmt_read) mgmt_readdata <= rd_mux;
    end

endmodule

// File: tb/tb_pll_hdmi_cfg.sv
// Randomised self-checking bench for pll_hdmi_cfg. It uses a short lock
// timeout so the timeout path fits in a short run.
module tb_pll_hdmi_cfg;

    localparam int RSTC = 16;
    localparam int TMO  = 300;
    localparam int STB  = 4;
    localparam int WL0  = RSTC + 2;   // first WAIT_LOCK cycle, counted from the START edge

    logic        refclk = 1'b0;
    logic        rst;
    logic [5:0]  mgmt_address;
    logic        mgmt_write;
    logic [31:0] mgmt_writedata;
    logic        mgmt_read;
    logic [31:0] mgmt_readdata;
    logic        mgmt_waitrequest;
    logic        pll_locked;
    logic        pll_rst;
    logic [15:0] cfg_m, cfg_n;
    logic [16:0] cfg_c0;
    logic [31:0] cfg_k;
    logic        cfg_valid, busy, lock_err;

    pll_hdmi_cfg #(.RST_CYCLES(RSTC), .LOCK_TIMEOUT(TMO), .LOCK_STABLE(STB)) dut (
        .refclk(refclk), .rst(rst),
        .mgmt_address(mgmt_address), .mgmt_write(mgmt_write),
        .mgmt_writedata(mgmt_writedata), .mgmt_read(mgmt_read),
        .mgmt_readdata(mgmt_readdata), .mgmt_waitrequest(mgmt_waitrequest),
        .pll_locked(pll_locked), .pll_rst(pll_rst),
        .cfg_m(cfg_m), .cfg_n(cfg_n), .cfg_c0(cfg_c0), .cfg_k(cfg_k),
        .cfg_valid(cfg_valid), .busy(busy), .lock_err(lock_err)
    );

    always #10 refclk = ~refclk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: shadow and active register sets plus the lock input per cycle.
    logic [15:0] sh_n, sh_m, ac_n, ac_m;
    logic [16:0] sh_c0, ac_c0;
    logic [31:0] sh_k, ac_k;
    bit          p [0:511];   // pll_locked driven in cycle k of a sequence

    task automatic tick();
        @(posedge refclk); #1;
    endtask

    task automatic model_reset();
        sh_n = 16'h0000; sh_m = 16'h0404; sh_c0 = 17'h10201; sh_k = 32'hE8F5C239;
        ac_n = sh_n; ac_m = sh_m; ac_c0 = sh_c0; ac_k = sh_k;
    endtask

    task automatic wr(input logic [5:0] a, input logic [31:0] d);
        mgmt_address = a; mgmt_writedata = d; mgmt_write = 1'b1;
        tick();
        mgmt_write = 1'b0;
        case (a)
            6'h03: sh_n  = d[15:0];
            6'h04: sh_m  = d[15:0];
            6'h05: sh_c0 = d[16:0];
            6'h07: sh_k  = d;
            default: ;
        endcase
    endtask

    task automatic rd(input logic [5:0] a, output logic [31:0] v);
        mgmt_address = a; mgmt_read = 1'b1;
        tick();
        mgmt_read = 1'b0;
        v = mgmt_readdata;
    endtask

    // Lock becomes visible two cycles into WAIT_LOCK. Busy drops once STB
    // consecutive visible highs are seen, or after TMO cycles with lock_err set.
    function automatic int exp_fall(output bit err);
        int run = 0;
        err = 1'b0;
        for (int w = 0; w < TMO; w++) begin
            bit o;
            o = (w >= 2) ? p[WL0 + w - 2] : 1'b0;
            run = o ? run + 1 : 0;
            if (run == STB) return WL0 + w + 1;
        end
        err = 1'b1;
        return WL0 + TMO;
    endfunction

    // One START sequence, checked against the model. With stall set, a write
    // to M is held on the bus for the whole sequence.
    task automatic run_seq(input bit stall, input logic [31:0] sd, output int meas_fall);
        logic [80:0] old_cfg, new_cfg, at_valid;
        int fall, bad_busy, bad_wait, bad_le, n_rst, first_rst, n_valid, valid_at;
        bit err, early_ok;
        fall = exp_fall(err);
        bad_busy = 0; bad_wait = 0; bad_le = 0; n_rst = 0; first_rst = 0;
        n_valid = 0; valid_at = 0; at_valid = '0; meas_fall = 0;
        old_cfg = {ac_n, ac_m, ac_c0, ac_k};
        mgmt_address = 6'h02; mgmt_writedata = $urandom; mgmt_write = 1'b1;
        tick();
        if (stall) begin mgmt_address = 6'h04; mgmt_writedata = sd; end
        else mgmt_write = 1'b0;
        ac_n = sh_n; ac_m = sh_m; ac_c0 = sh_c0; ac_k = sh_k;
        new_cfg = {ac_n, ac_m, ac_c0, ac_k};
        early_ok = ({cfg_n, cfg_m, cfg_c0, cfg_k} === old_cfg);
        for (int k = 1; k <= fall; k++) begin
            pll_locked = p[k];
            #1;
            if (busy !== (k < fall)) bad_busy++;
            if (!busy && meas_fall == 0) meas_fall = k;
            if (pll_rst === 1'b1) begin n_rst++; if (first_rst == 0) first_rst = k; end
            if (cfg_valid === 1'b1) begin n_valid++; valid_at = k; at_valid = {cfg_n, cfg_m, cfg_c0, cfg_k}; end
            if (k == 2 && lock_err !== 1'b0) bad_le++;
            if (stall && mgmt_waitrequest !== (k < fall)) bad_wait++;
            if (k < fall) tick();
        end
        if (stall) begin tick(); mgmt_write = 1'b0; sh_m = sd[15:0]; end

        n_tests++; if (!early_ok) begin n_fail++; $display("FAIL seq_cfg_early: cfg changed in APPLY cycle, expected %h", old_cfg); end
        n_tests++; if (bad_busy != 0) begin n_fail++; $display("FAIL seq_busy: %0d bad cycles, busy should fall at cycle %0d (seen %0d)", bad_busy, fall, meas_fall); end
        n_tests++; if (n_rst != RSTC || first_rst != 2) begin n_fail++; $display("FAIL seq_pll_rst: %0d cycles from %0d, expected %0d from 2", n_rst, first_rst, RSTC); end
        n_tests++; if (n_valid != 1 || valid_at != 2) begin n_fail++; $display("FAIL seq_cfg_valid: %0d pulses at %0d, expected 1 at 2", n_valid, valid_at); end
        n_tests++; if (at_valid !== new_cfg) begin n_fail++; $display("FAIL seq_cfg_at_valid: %h expected %h", at_valid, new_cfg); end
        n_tests++; if (bad_le != 0) begin n_fail++; $display("FAIL seq_lock_err_clear: lock_err not 0 after APPLY"); end
        n_tests++; if (lock_err !== err) begin n_fail++; $display("FAIL seq_lock_err: %b expected %b", lock_err, err); end
        n_tests++; if ({cfg_n, cfg_m, cfg_c0, cfg_k} !== new_cfg) begin n_fail++; $display("FAIL seq_cfg_final: %h expected %h", {cfg_n, cfg_m, cfg_c0, cfg_k}, new_cfg); end
        if (stall) begin
            n_tests++; if (bad_wait != 0) begin n_fail++; $display("FAIL seq_waitrequest: %0d bad cycles", bad_wait); end
        end
    endtask

    task automatic test_reset();
        logic [31:0] v;
        rst = 1'b1; mgmt_address = '0; mgmt_write = 1'b0; mgmt_writedata = '0;
        mgmt_read = 1'b0; pll_locked = 1'b0;
        model_reset();
        repeat (3) tick();
        n_tests++;
        if ({busy, pll_rst, cfg_valid, lock_err, mgmt_waitrequest, mgmt_readdata} !== 37'd0) begin
            n_fail++; $display("FAIL reset_outputs: %b expected all zero", {busy, pll_rst, cfg_valid, lock_err, mgmt_waitrequest, mgmt_readdata});
        end
        rst = 1'b0;
        tick();
        rd(6'h00, v);
        n_tests++; if (v !== 32'h0) begin n_fail++; $display("FAIL reset_status: %h expected 0", v); end
        n_tests++; if (cfg_m !== 16'h0404) begin n_fail++; $display("FAIL reset_cfg_m: %h expected 0404", cfg_m); end
        n_tests++; if (cfg_k !== 32'hE8F5C239) begin n_fail++; $display("FAIL reset_cfg_k: %h expected e8f5c239", cfg_k); end
        n_tests++; if ({cfg_n, cfg_c0} !== {16'h0000, 17'h10201}) begin n_fail++; $display("FAIL reset_cfg_n_c0: %h %h expected 0000 10201", cfg_n, cfg_c0); end
    endtask

    task automatic test_basic();
        int mf;
        wr(6'h04, 32'h0000_0505);
        wr(6'h07, 32'h1234_5678);
        for (int i = 0; i < 512; i++) p[i] = 1'b1;
        run_seq(1'b0, 32'h0, mf);
        n_tests++; if (mf !== RSTC + 8) begin n_fail++; $display("FAIL basic_busy_fall: cycle %0d expected %0d", mf, RSTC + 8); end
        n_tests++; if ({cfg_m, cfg_k} !== {16'h0505, 32'h12345678}) begin n_fail++; $display("FAIL basic_cfg: %h %h expected 0505 12345678", cfg_m, cfg_k); end
    endtask

    task automatic test_unmapped();
        logic [31:0] v;
        int mf;
        wr(6'h01, 32'hDEAD_BEEF);
        wr(6'h06, 32'hCAFE_F00D);
        wr(6'h3F, 32'h5555_AAAA);
        wr(6'h05, 32'h0001_2345);
        rd(6'h01, v);
        n_tests++; if (v !== 32'h0) begin n_fail++; $display("FAIL unmapped_read_01: %h expected 0", v); end
        rd(6'h3F, v);
        n_tests++; if (v !== 32'h0) begin n_fail++; $display("FAIL unmapped_read_3f: %h expected 0", v); end
        rd(6'h05, v);
`ifdef PLL_HDMI_CFG_READBACK_EN
        n_tests++; if (v !== {15'd0, sh_c0}) begin n_fail++; $display("FAIL readback_c0: %h expected %h", v, {15'd0, sh_c0}); end
`else
        n_tests++; if (v !== 32'h0) begin n_fail++; $display("FAIL readback_c0_off: %h expected 0", v); end
`endif
        for (int i = 0; i < 512; i++) p[i] = 1'b1;
        run_seq(1'b0, 32'h0, mf);
    endtask

    task automatic test_stall();
        int mf;
        logic [15:0] m_before;
        for (int i = 0; i < 512; i++) p[i] = 1'b1;
        run_seq(1'b1, 32'h0000_0A0B, mf);
        m_before = ac_m;
        n_tests++; if (cfg_m !== m_before) begin n_fail++; $display("FAIL stall_cfg_m_unchanged: %h expected %h", cfg_m, m_before); end
        run_seq(1'b0, 32'h0, mf);
        n_tests++; if (cfg_m !== 16'h0A0B) begin n_fail++; $display("FAIL stall_write_landed: %h expected 0a0b", cfg_m); end
    endtask

    task automatic test_timeout();
        logic [31:0] v;
        int mf;
        for (int i = 0; i < 512; i++) p[i] = 1'b0;
        run_seq(1'b0, 32'h0, mf);
        n_tests++; if (mf !== WL0 + TMO) begin n_fail++; $display("FAIL timeout_fall: cycle %0d expected %0d", mf, WL0 + TMO); end
        rd(6'h00, v);
        n_tests++; if (v !== 32'h4) begin n_fail++; $display("FAIL timeout_status: %h expected 4", v); end
        for (int i = 0; i < 512; i++) p[i] = 1'b1;
        run_seq(1'b0, 32'h0, mf);
        n_tests++; if (lock_err !== 1'b0) begin n_fail++; $display("FAIL timeout_cleared: %b expected 0", lock_err); end
    endtask

    task automatic test_lock_glitch();
        int mf;
        for (int i = 0; i < 512; i++) p[i] = 1'b1;
        p[WL0 + 3] = 1'b0;   // visible lock: 1,1,1,0,1,1,1,1
        run_seq(1'b0, 32'h0, mf);
        n_tests++; if (mf !== RSTC + 12) begin n_fail++; $display("FAIL glitch_fall: cycle %0d expected %0d", mf, RSTC + 12); end
    endtask

    task automatic test_reset_mid();
        int n_bad;
        mgmt_address = 6'h02; mgmt_write = 1'b1;
        tick();
        mgmt_write = 1'b0;
        repeat (4) tick();
        #3 rst = 1'b1;
        #1;
        model_reset();
        n_tests++;
        if ({busy, pll_rst, cfg_valid, lock_err, mgmt_readdata} !== 36'd0) begin
            n_fail++; $display("FAIL reset_mid_outputs: %b expected all zero", {busy, pll_rst, cfg_valid, lock_err, mgmt_readdata});
        end
        n_tests++;
        if ({cfg_n, cfg_m, cfg_c0, cfg_k} !== {ac_n, ac_m, ac_c0, ac_k}) begin
            n_fail++; $display("FAIL reset_mid_cfg: %h expected %h", {cfg_n, cfg_m, cfg_c0, cfg_k}, {ac_n, ac_m, ac_c0, ac_k});
        end
        tick();
        rst = 1'b0;
        n_bad = 0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (cfg_valid !== 1'b0 || busy !== 1'b0) n_bad++;
        end
        n_tests++; if (n_bad != 0) begin n_fail++; $display("FAIL reset_mid_quiet: %0d cycles with cfg_valid/busy, expected 0", n_bad); end
    endtask

    task automatic test_random();
        int mf, mode;
        logic [5:0] a;
        for (int it = 0; it < 6; it++) begin
            for (int j = 0; j < 4; j++) begin
                case ($urandom_range(0, 5))
                    0: a = 6'h03;
                    1: a = 6'h04;
                    2: a = 6'h05;
                    3: a = 6'h07;
                    default: a = 6'($urandom_range(0, 63));
                endcase
                if (a == 6'h02) a = 6'h07;
                wr(a, $urandom);
            end
            mode = (it == 2) ? 1 : $urandom_range(0, 2);
            for (int i = 0; i < 512; i++)
                p[i] = (mode == 1) ? 1'b0 : (mode == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 1) == 1);
            run_seq(bit'($urandom_range(0, 1)), $urandom, mf);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_unmapped();
        test_stall();
        test_timeout();
        test_lock_glitch();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pll_hdmi_cfg.md
PLL_HDMI_CFG -- requirements
Module: pll_hdmi_cfg

Interface
REQ-001 Parameter RST_CYCLES, default 16: number of refclk cycles pll_rst is held high per reconfiguration.
REQ-002 Parameter LOCK_TIMEOUT, default 1000000: number of refclk cycles allowed for lock (20 ms at 50 MHz).
REQ-003 Parameter LOCK_STABLE, default 4: number of consecutive synchronised-high cycles that qualify lock.
REQ-004 refclk  in  1  50 MHz management clock; the only clock in the block.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 mgmt_address  in  6  register word address.
REQ-007 mgmt_write  in  1  write strobe.
REQ-008 mgmt_writedata  in  32  write data.
REQ-009 mgmt_read  in  1  read strobe.
REQ-010 mgmt_readdata  out  32  read data, registered.
REQ-011 mgmt_waitrequest  out  1  write stall.
REQ-012 pll_locked  in  1  PLL lock, asynchronous to refclk.
REQ-013 pll_rst  out  1  PLL reset request.
REQ-014 cfg_m  out  16  active M counter {hi[15:8], lo[7:0]}.
REQ-015 cfg_n  out  16  active N counter {hi, lo}; 0 = bypass.
REQ-016 cfg_c0  out  17  active C0 counter {odd_en[16], hi[15:8], lo[7:0]}.
REQ-017 cfg_k  out  32  active fractional K.
REQ-018 cfg_valid  out  1  one-cycle pulse when the active values change.
REQ-019 busy  out  1  high while a sequence is running.
REQ-020 lock_err  out  1  sticky flag: last sequence timed out.

Function
REQ-021 The register map SHALL be: 0x00 STATUS (read-only: bit0 busy, bit1 locked_q, bit2 lock_err); 0x02 START (write, data ignored); 0x03 N[15:0]; 0x04 M[15:0]; 0x05 C0[16:0]; 0x07 K[31:0].
REQ-022 Writes to 0x03–0x07 SHALL update shadow registers only; active cfg_* outputs SHALL NOT change until the START sequence.
REQ-023 Writes to unmapped addresses SHALL be ignored.
REQ-024 mgmt_waitrequest SHALL be high whenever busy=1 and mgmt_write=1; it SHALL be low in all other cases.
REQ-025 While mgmt_waitrequest is high, the stalled write SHALL have no effect until it is accepted.
REQ-026 mgmt_readdata SHALL be valid on the cycle after mgmt_read.
REQ-027 Reads SHALL never stall.
REQ-028 Unmapped reads SHALL return 0.
REQ-029 pll_locked SHALL pass through a two-flop synchroniser to produce locked_q.
REQ-030 The FSM SHALL have the states IDLE, APPLY, RST_HOLD, WAIT_LOCK.
REQ-031 IDLE→APPLY SHALL occur on an accepted START write; busy SHALL rise on the next cycle.
REQ-032 In APPLY (one cycle), the FSM SHALL copy shadow→active, pulse cfg_valid for exactly one cycle, and set pll_rst=1 and lock_err=0.
REQ-033 In RST_HOLD, pll_rst SHALL stay high for exactly RST_CYCLES cycles; the FSM SHALL then clear pll_rst and enter WAIT_LOCK.
REQ-034 In WAIT_LOCK, when locked_q has been high for LOCK_STABLE consecutive cycles, the FSM SHALL return to IDLE and set busy=0.
REQ-035 Any low cycle of locked_q SHALL restart the stability count.
REQ-036 If LOCK_TIMEOUT cycles elapse in WAIT_LOCK without qualified lock, the FSM SHALL set lock_err=1 and go to IDLE with pll_rst=0.
REQ-037 A START write and a shadow write SHALL never be accepted in the same cycle, because only one address exists per access.
REQ-038 A shadow write accepted in IDLE on the cycle before START SHALL be included in the APPLY.
REQ-039 Counters SHALL saturate, not wrap: the timeout counter SHALL be 20 bits wide for the default value and sized $clog2(LOCK_TIMEOUT+1) in general.

Reset
REQ-040 Reset SHALL place the FSM in IDLE.
REQ-041 Reset SHALL set busy=0, pll_rst=0, cfg_valid=0, lock_err=0, mgmt_readdata=0 and mgmt_waitrequest=0.
REQ-042 Reset SHALL set the active and shadow registers to M=0x0404, N=0x0000, C0=0x10201 and K=0xE8F5C239 (148.5 MHz).
REQ-043 Reset asserted mid-sequence SHALL abort immediately with the values in REQ-040 to REQ-042; no cfg_valid pulse SHALL follow.

Configuration
REQ-044 With macro PLL_HDMI_CFG_READBACK_EN defined, reads of 0x03/0x04/0x05/0x07 SHALL return the shadow registers, zero-extended.
REQ-045 Without PLL_HDMI_CFG_READBACK_EN, reads of 0x03/0x04/0x05/0x07 SHALL return 0, and the read mux for those addresses SHALL be absent.

Verification
REQ-046 Reset release followed by a read of 0x00 -> readdata=0; cfg_m=0x0404; cfg_k=0xE8F5C239.
REQ-047 Write M=0x0505 and K=0x12345678, then START, with pll_locked held high -> cfg_valid pulses once; pll_rst is high for 16 cycles; busy falls 4+2 cycles after pll_rst falls; the outputs equal the written values.
REQ-048 Write to 0x04 while busy -> waitrequest is high until IDLE; the write then lands in shadow only, and cfg_m is unchanged.
REQ-049 START with pll_locked=0 -> lock_err=1 after 1000000 WAIT_LOCK cycles; STATUS reads 0x4; a new START clears lock_err.
REQ-050 pll_locked toggles 1,1,1,0,1,1,1,1 in WAIT_LOCK -> busy falls only after the final four highs; rst pulsed in RST_HOLD -> pll_rst=0 and busy=0 at once.
